// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter: grants one of two burst requesters access to a single-port async ROM.
// Define ROM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (port 0 wins).
module rom_burst_arbiter #(
    parameter int ADDRWIDTH = 4,
    parameter int DATAWIDTH = 8,
    parameter int LENWIDTH  = 4
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iReq0,
    input  logic                 iReq1,
    input  logic [ADDRWIDTH-1:0] iAddr0,
    input  logic [ADDRWIDTH-1:0] iAddr1,
    input  logic [LENWIDTH-1:0]  iLen0,
    input  logic [LENWIDTH-1:0]  iLen1,
    output logic                 oGnt0,
    output logic                 oGnt1,
    output logic                 oValid0,
    output logic                 oValid1,
    output logic                 oLast0,
    output logic                 oLast1,
    output logic [DATAWIDTH-1:0] oData0,
    output logic [DATAWIDTH-1:0] oData1,
    output logic                 oBusy,
    output logic [ADDRWIDTH-1:0] oRomAddr,
    input  logic [DATAWIDTH-1:0] iRomData
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t               state, state_nxt;
    logic [ADDRWIDTH-1:0] raddr, raddr_nxt;
    logic [LENWIDTH-1:0]  rcount, rcount_nxt;
    logic                 rowner, rowner_nxt;
    logic [DATAWIDTH-1:0] rdata;
    logic [1:0]           rvalid, rvalid_nxt, rlast, rlast_nxt;
    logic                 idle;
    assign idle = state == IDLE;
`ifdef ROM_ARB_RR_EN
    logic rprio;
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)
            rprio <= 1'b0;
        else if (oGnt0 || oGnt1)
            rprio <= oGnt0;
    end
    // a lone requester wins regardless of the pointer
    assign oGnt0 = idle && iReq0 && (!iReq1 || !rprio);
    assign oGnt1 = idle && iReq1 && (!iReq0 || rprio);
`else
    assign oGnt0 = idle && iReq0;
    assign oGnt1 = idle && iReq1 && !iReq0;
`endif
    always_comb begin
        state_nxt  = state;
        raddr_nxt  = raddr;
        rcount_nxt = rcount;
        rowner_nxt = rowner;
        rvalid_nxt = 2'b00;
        rlast_nxt  = 2'b00;
        if (idle) begin
            if (oGnt0 || oGnt1) begin
                state_nxt  = BURST;
                raddr_nxt  = oGnt0 ? iAddr0 : iAddr1;
                rcount_nxt = oGnt0 ? iLen0 : iLen1;
                rowner_nxt = oGnt1;
            end
        end else begin
            raddr_nxt  = raddr + ADDRWIDTH'(1);
            rvalid_nxt = rowner ? 2'b10 : 2'b01;
            if (rcount == '0) begin
                rlast_nxt = rvalid_nxt;
                state_nxt = IDLE;
            end else
                rcount_nxt = rcount - LENWIDTH'(1);
        end
    end
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state  <= IDLE;
            raddr  <= '0;
            rcount <= '0;
            rowner <= 1'b0;
            rdata  <= '0;
            rvalid <= 2'b00;
            rlast  <= 2'b00;
        end else begin
            state  <= state_nxt;
            raddr  <= raddr_nxt;
            rcount <= rcount_nxt;
            rowner <= rowner_nxt;
            rvalid <= rvalid_nxt;
            rlast  <= rlast_nxt;
            if (!idle)
                rdata <= iRomData;
        end
    end
    assign oValid0  = rvalid[0];
    assign oValid1  = rvalid[1];
    assign oLast0   = rlast[0];
    assign oLast1   = rlast[1];
    assign oData0   = rdata;
    assign oData1   = rdata;
    assign oBusy    = !idle;
    assign oRomAddr = raddr;
endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb_rom_burst_arbiter: directed bench with a word-counting reference model checked every cycle.
module tb_rom_burst_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0, len0 = '0, len1 = '0;
    logic       gnt0, gnt1, valid0, valid1, last0, last1, busy;
    logic [7:0] data0, data1, romdata;
    logic [3:0] romaddr;
    logic [7:0] rom [16];
    int checks = 0, errors = 0;
    logic en_cmp = 1'b0;
    logic [8:0] q0[$], q1[$];
    int gq[$];
    int busy_cnt = 0;

    always #5 clk = ~clk;
    assign romdata = rom[romaddr];

    rom_burst_arbiter #(.ADDRWIDTH(4), .DATAWIDTH(8), .LENWIDTH(4)) dut (
        .iClk(clk), .iRst_n(rst_n),
        .iReq0(req0), .iReq1(req1),
        .iAddr0(addr0), .iAddr1(addr1),
        .iLen0(len0), .iLen1(len1),
        .oGnt0(gnt0), .oGnt1(gnt1),
        .oValid0(valid0), .oValid1(valid1),
        .oLast0(last0), .oLast1(last1),
        .oData0(data0), .oData1(data1),
        .oBusy(busy), .oRomAddr(romaddr), .iRomData(romdata)
    );

    // reference: a burst is a count of remaining words; outputs are what the ROM held one edge earlier
    int         m_left;
    logic [3:0] m_addr;
    logic       m_own, m_prio;
    logic [1:0] e_valid, e_last;
    logic [7:0] e_data;
    logic       m_g0, m_g1;

    always_comb begin
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (m_left == 0) begin
`ifdef ROM_ARB_RR_EN
            m_g0 = req0 && !(req1 && m_prio);
            m_g1 = req1 && !(req0 && !m_prio);
`else
            m_g0 = req0;
            m_g1 = req1 && !req0;
`endif
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_addr  <= '0;
            m_own   <= 1'b0;
            m_prio  <= 1'b0;
            e_valid <= 2'b00;
            e_last  <= 2'b00;
            e_data  <= '0;
        end else if (m_left > 0) begin
            e_data  <= rom[m_addr];
            e_valid <= m_own ? 2'b10 : 2'b01;
            e_last  <= (m_left == 1) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
            m_addr  <= m_addr + 4'd1;
            m_left  <= m_left - 1;
        end else begin
            e_valid <= 2'b00;
            e_last  <= 2'b00;
            if (m_g0) begin
                m_addr <= addr0; m_left <= int'(len0) + 1; m_own <= 1'b0; m_prio <= 1'b1;
            end else if (m_g1) begin
                m_addr <= addr1; m_left <= int'(len1) + 1; m_own <= 1'b1; m_prio <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en_cmp) begin
            chk("gnt0", gnt0, m_g0);
            chk("gnt1", gnt1, m_g1);
            chk("valid0", valid0, e_valid[0]);
            chk("valid1", valid1, e_valid[1]);
            chk("last0", last0, e_last[0]);
            chk("last1", last1, e_last[1]);
            chk("data0", data0, e_data);
            chk("data1", data1, e_data);
            chk("busy", busy, m_left > 0);
            chk("romaddr", romaddr, m_addr);
        end
        if (valid0) q0.push_back({last0, data0});
        if (valid1) q1.push_back({last1, data1});
        if (gnt0) gq.push_back(0);
        if (gnt1) gq.push_back(1);
        if (busy) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        q0.delete();
        q1.delete();
        gq.delete();
        busy_cnt = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'(i);
        tick();
        tick();
        rst_n = 1'b1;
        en_cmp = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_data", data0, 0);
        tick();

        // single burst 3,4,5
        clear();
        req0 = 1'b1; addr0 = 4'd3; len0 = 4'd2;
        @(negedge clk);
        chk("t1_gnt0", gnt0, 1);
        tick();
        req0 = 1'b0;
        repeat (6) tick();
        chk("t1_gcount", gq.size(), 1);
        chk("t1_n0", q0.size(), 3);
        chk("t1_n1", q1.size(), 0);
        if (q0.size() == 3) begin
            chk("t1_w0", q0[0], {1'b0, 8'd3});
            chk("t1_w1", q0[1], {1'b0, 8'd4});
            chk("t1_w2", q0[2], {1'b1, 8'd5});
        end

        // wrap-around on port 1
        clear();
        req1 = 1'b1; addr1 = 4'd14; len1 = 4'd3;
        tick();
        req1 = 1'b0;
        repeat (7) tick();
        chk("t2_busy_cycles", busy_cnt, 4);
        chk("t2_n1", q1.size(), 4);
        chk("t2_n0", q0.size(), 0);
        if (q1.size() == 4) begin
            chk("t2_w0", q1[0], {1'b0, 8'd14});
            chk("t2_w1", q1[1], {1'b0, 8'd15});
            chk("t2_w2", q1[2], {1'b0, 8'd0});
            chk("t2_w3", q1[3], {1'b1, 8'd1});
        end

        // simultaneous single-word requests held for 8 cycles
        clear();
        req0 = 1'b1; req1 = 1'b1; addr0 = 4'd7; addr1 = 4'd9; len0 = 4'd0; len1 = 4'd0;
        repeat (8) tick();
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();
        chk("t3_gcount", gq.size(), 4);
        if (gq.size() == 4) begin
`ifdef ROM_ARB_RR_EN
            chk("t3_g0", gq[0], 0);
            chk("t3_g1", gq[1], 1);
            chk("t3_g2", gq[2], 0);
            chk("t3_g3", gq[3], 1);
`else
            for (int i = 0; i < 4; i++) chk("t3_g", gq[i], 0);
`endif
        end
`ifdef ROM_ARB_RR_EN
        chk("t3_n0", q0.size(), 2);
        chk("t3_n1", q1.size(), 2);
`else
        chk("t3_n0", q0.size(), 4);
        chk("t3_n1", q1.size(), 0);
`endif

        // request arriving mid-burst waits for the idle cycle
        clear();
        req0 = 1'b1; addr0 = 4'd0; len0 = 4'd3;
        tick();
        req0 = 1'b0;
        tick();
        req1 = 1'b1; addr1 = 4'd5; len1 = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_gnt1_wait", gnt1, 0);
            tick();
        end
        @(negedge clk);
        chk("t4_gnt1", gnt1, 1);
        chk("t4_last0", last0, 1);
        tick();
        req1 = 1'b0;
        @(negedge clk);
        chk("t4_valid1_early", valid1, 0);
        tick();
        @(negedge clk);
        chk("t4_valid1", valid1, 1);
        chk("t4_data1", data1, 5);
        repeat (3) tick();

        // reset during word 2 of an 8-word burst
        clear();
        req0 = 1'b1; addr0 = 4'd2; len0 = 4'd7;
        tick();
        req0 = 1'b0;
        repeat (3) tick();
        #1;
        chk("t5_pre_valid0", valid0, 1);
        chk("t5_pre_data0", data0, 4);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valid0", valid0, 0);
        chk("t5_busy", busy, 0);
        chk("t5_data0", data0, 0);
        chk("t5_romaddr", romaddr, 0);
        tick();
        rst_n = 1'b1;
        clear();
        repeat (6) tick();
        chk("t5_no_words", q0.size() + q1.size(), 0);

        // maximum length burst from address 0
        clear();
        req0 = 1'b1; addr0 = 4'd0; len0 = 4'd15;
        tick();
        req0 = 1'b0;
        repeat (20) tick();
        chk("t6_n0", q0.size(), 16);
        if (q0.size() == 16)
            for (int i = 0; i < 16; i++) chk("t6_w", q0[i], {i == 15, 8'(i)});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
